clint_timer: RTL and testbench
==============================

CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bus data width; fixed at 32.
REQ-002 Parameter PRESCALE, default 1: clk cycles per mtime increment; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 arst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-005 i_req_valid  input  1  bus request present.
REQ-006 i_req_write  input  1  1 = write, 0 = read.
REQ-007 i_req_addr  input  3  word register index.
REQ-008 i_req_wdata  input  32  write data.
REQ-009 o_req_ready  output  1  request accepted this cycle when high with i_req_valid.
REQ-010 o_rsp_valid  output  1  one-cycle pulse marking completion of an accepted request.
REQ-011 o_rsp_rdata  output  32  read data, valid with o_rsp_valid; 0 for writes.
REQ-012 o_timer_int_call  output  1  level, drives CSR i_timer_int_call (mip.MTIP).
REQ-013 o_software_int_call  output  1  level, drives CSR i_software_int_call (mip.MSIP).

Function
REQ-014 Register map: 0 msip (bit0 only, others read 0); 1 mtimecmp_lo; 2 mtimecmp_hi; 3 mtime_lo; 4 mtime_hi (shadow read); 5 ctrl (bit0 = count enable, others read 0); 6-7 reserved: reads return 0, writes ignored.
REQ-015 FSM states IDLE and RESP; IDLE -> RESP on i_req_valid; RESP -> IDLE unconditionally the next cycle.
REQ-016 o_req_ready = 1 in IDLE, 0 in RESP; a request is accepted only on a cycle with i_req_valid & o_req_ready.
REQ-017 Accepted write updates the target register at the accepting edge; o_rsp_valid = 1 during the following (RESP) cycle.
REQ-018 Accepted read: o_rsp_rdata and o_rsp_valid = 1 during the following (RESP) cycle; read latency exactly 1 cycle; back-to-back throughput one request per 2 cycles.
REQ-019 Prescaler counter 8-bit; counts only when ctrl.bit0 = 1; when it reaches PRESCALE-1 it returns to 0 and mtime increments by 1 that cycle.
REQ-020 mtime is 64-bit unsigned; 0xFFFF_FFFF_FFFF_FFFF increments to 0 (wrap, no flag).
REQ-021 Bus write to mtime_lo/mtime_hi in the same cycle as an increment: bus write wins for the written half; the other half keeps its old value (no carry applied that cycle).
REQ-022 Bus write to mtime or ctrl also clears the prescaler counter to 0.
REQ-023 Read of mtime_lo returns mtime[31:0] and, at the accepting edge, copies mtime[63:32] into a 32-bit shadow; read of index 4 returns the shadow, not live mtime_hi.
REQ-024 o_timer_int_call registered: next value = (mtime >= mtimecmp), 64-bit unsigned compare, evaluated on current register values; 1-cycle lag after any change.
REQ-025 o_software_int_call = msip bit0, registered (direct flop output).
REQ-026 Counting is unaffected by bus activity other than REQ-021/REQ-022.

Reset
REQ-027 On arst = 0, immediately: FSM = IDLE, msip = 0, mtimecmp = 0xFFFF_FFFF_FFFF_FFFF, mtime = 0, shadow = 0, ctrl = 0x1, prescaler = 0.
REQ-028 During reset: o_req_ready = 1 only after release (0 while arst = 0), o_rsp_valid = 0, o_rsp_rdata = 0, o_timer_int_call = 0, o_software_int_call = 0.
REQ-029 Reset asserted in RESP aborts the response; no o_rsp_valid after release for that request.
REQ-030 First count occurs PRESCALE cycles after reset release.

Verification
REQ-031 PRESCALE=1, reset release, wait 10 cycles, read mtime_lo -> rdata 10 +/- 1 (bench computes exact), rsp 1 cycle after accept.
REQ-032 Write mtimecmp_hi = 0, mtimecmp_lo = 20 with mtime counting from 0 -> o_timer_int_call rises exactly one cycle after mtime reaches 20; write mtimecmp_lo = 0xFFFF_FFFF, mtimecmp_hi = 0xFFFF_FFFF -> falls one cycle later.
REQ-033 Write msip = 0xFFFF_FFFF -> o_software_int_call = 1 next cycle, read msip = 0x1; write 0 -> clears.
REQ-034 Write mtime_hi = 0xFFFF_FFFF, mtime_lo = 0xFFFF_FFFE -> after 2 increments mtime = 0 (wrap); read lo then hi returns consistent 64-bit snapshot.
REQ-035 PRESCALE=4, write ctrl = 0 -> mtime frozen; ctrl = 1 -> increments every 4 cycles; held i_req_valid for 4 requests -> o_req_ready alternates 1,0 and exactly 4 o_rsp_valid pulses.
REQ-036 arst asserted mid-RESP -> all outputs at reset values asynchronously, mtimecmp reads 0xFFFF_FFFF after release, no stray o_rsp_valid.

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: machine timer and software-interrupt block with a simple valid/ready register port.
// Latency: a request is accepted in IDLE and answered one cycle later. Reads take exactly 1 cycle.
// Backpressure: o_req_ready is low in the RESP cycle, so sustained throughput is 1 request per 2 cycles.
// Ports: clk/arst (async active-low); i_req_* request (valid/write/addr/wdata); o_req_ready;
//        o_rsp_valid/o_rsp_rdata response pulse; o_timer_int_call (mtime >= mtimecmp); o_software_int_call (msip).
module clint_timer #(
  parameter int DATA_WIDTH = 32,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_req_valid,
  input  logic                  i_req_write,
  input  logic [2:0]            i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_req_ready,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_timer_int_call,
  output logic                  o_software_int_call
);

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  state_e                state_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  msip_q;
  logic                  ctrl_en_q;
  logic                  tint_q;
  logic [63:0]           mtimecmp_q;
  logic [63:0]           mtime_q, mtime_d;
  logic [31:0]           shadow_q;
  logic [7:0]            presc_q, presc_d;

  logic accept, wr_acc, rd_acc, tick, mtime_wr, presc_clr;

  // Ready is held low while reset is asserted even though the FSM already sits in IDLE.
  assign o_req_ready = arst & (state_q == ST_IDLE);

  assign accept    = i_req_valid & (state_q == ST_IDLE);
  assign wr_acc    = accept & i_req_write;
  assign rd_acc    = accept & ~i_req_write;
  assign tick      = ctrl_en_q & (presc_q == PRESC_LAST);
  assign mtime_wr  = wr_acc & ((i_req_addr == 3'd3) | (i_req_addr == 3'd4));
  assign presc_clr = mtime_wr | (wr_acc & (i_req_addr == 3'd5));

  always_comb begin
    presc_d = presc_q;
    if (presc_clr) begin
      presc_d = '0;
    end else if (ctrl_en_q) begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
    end
  end

  // A bus write to either half suppresses the increment for that cycle entirely,
  // so no carry leaks into the half that was not written.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_acc && (i_req_addr == 3'd3)) begin
      mtime_d[31:0] = i_req_wdata;
    end else if (wr_acc && (i_req_addr == 3'd4)) begin
      mtime_d[63:32] = i_req_wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      case (i_req_addr)
        3'd0:    rdata_d = {{(DATA_WIDTH-1){1'b0}}, msip_q};
        3'd1:    rdata_d = mtimecmp_q[31:0];
        3'd2:    rdata_d = mtimecmp_q[63:32];
        3'd3:    rdata_d = mtime_q[31:0];
        3'd4:    rdata_d = shadow_q;
        3'd5:    rdata_d = {{(DATA_WIDTH-1){1'b0}}, ctrl_en_q};
        default: rdata_d = '0;
      endcase
    end
  end

  // Bus FSM and response registers.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= i_req_valid ? ST_RESP : ST_IDLE;
        ST_RESP: state_q <= ST_IDLE;
      endcase
      rsp_valid_q <= accept;
      rdata_q     <= rdata_d;
    end
  end

  // Timer state and register file.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      msip_q     <= 1'b0;
      ctrl_en_q  <= 1'b1;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
      shadow_q   <= '0;
      presc_q    <= '0;
      tint_q     <= 1'b0;
    end else begin
      if (wr_acc) begin
        case (i_req_addr)
          3'd0:    msip_q             <= i_req_wdata[0];
          3'd1:    mtimecmp_q[31:0]   <= i_req_wdata;
          3'd2:    mtimecmp_q[63:32]  <= i_req_wdata;
          3'd5:    ctrl_en_q          <= i_req_wdata[0];
          default: ;
        endcase
      end
      // Reading mtime_lo latches the upper half so a following mtime_hi read is coherent.
      if (rd_acc && (i_req_addr == 3'd3)) begin
        shadow_q <= mtime_q[63:32];
      end
      mtime_q <= mtime_d;
      presc_q <= presc_d;
      tint_q  <= (mtime_q >= mtimecmp_q);
    end
  end

  assign o_rsp_valid         = rsp_valid_q;
  assign o_rsp_rdata         = rdata_q;
  assign o_timer_int_call    = tint_q;
  assign o_software_int_call = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
module tb_clint_timer;

  localparam int P0 = 1;
  localparam int P1 = 4;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        vld    [2];
  logic        wr_s   [2];
  logic [2:0]  addr_s [2];
  logic [31:0] wdat   [2];
  logic        rdy    [2];
  logic        rsp_vld[2];
  logic [31:0] rdata  [2];
  logic        tint   [2];
  logic        sint   [2];

  always #5 clk = ~clk;

  clint_timer #(.DATA_WIDTH(32), .PRESCALE(P0)) dut0 (
    .clk(clk), .arst(arst),
    .i_req_valid(vld[0]), .i_req_write(wr_s[0]), .i_req_addr(addr_s[0]), .i_req_wdata(wdat[0]),
    .o_req_ready(rdy[0]), .o_rsp_valid(rsp_vld[0]), .o_rsp_rdata(rdata[0]),
    .o_timer_int_call(tint[0]), .o_software_int_call(sint[0])
  );

  clint_timer #(.DATA_WIDTH(32), .PRESCALE(P1)) dut1 (
    .clk(clk), .arst(arst),
    .i_req_valid(vld[1]), .i_req_write(wr_s[1]), .i_req_addr(addr_s[1]), .i_req_wdata(wdat[1]),
    .o_req_ready(rdy[1]), .o_rsp_valid(rsp_vld[1]), .o_rsp_rdata(rdata[1]),
    .o_timer_int_call(tint[1]), .o_software_int_call(sint[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mtime is an affine function of the edge count since the last
  // event that restarted counting (reset, mtime write, ctrl write).
  int          cyc;
  logic [63:0] base_m   [2];
  int          anch_m   [2];
  logic        en_m     [2];
  logic        msip_m   [2];
  logic [63:0] cmp_m    [2];
  logic [31:0] shadow_m [2];
  int          exp_cnt  [2];
  int          rsp_cnt  [2];
  logic        have_prev[2];
  logic        ge_prev  [2];

  always @(posedge clk or negedge arst) begin
    if (!arst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [63:0] mt(input int d, input int n);
    int p;
    p = (d == 0) ? P0 : P1;
    if (!en_m[d]) return base_m[d];
    return base_m[d] + 64'((n - anch_m[d]) / p);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      base_m[d]   = '0;
      anch_m[d]   = 0;
      en_m[d]     = 1'b1;
      msip_m[d]   = 1'b0;
      cmp_m[d]    = '1;
      shadow_m[d] = '0;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_val({tag, "_rdy"},   64'(rdy[d]),     64'd0);
      check_val({tag, "_rsp"},   64'(rsp_vld[d]), 64'd0);
      check_val({tag, "_rdata"}, 64'(rdata[d]),   64'd0);
      check_val({tag, "_mtip"},  64'(tint[d]),    64'd0);
      check_val({tag, "_msip"},  64'(sint[d]),    64'd0);
    end
  endtask

  task automatic do_req(input int d, input logic wr, input logic [2:0] a, input logic [31:0] wd);
    logic [63:0] v;
    logic [31:0] exp_rd;
    int          e;
    @(negedge clk);
    check_val("req_rdy_idle", 64'(rdy[d]), 64'd1);
    check_val("rsp_quiet", 64'(rsp_vld[d]), 64'd0);
    vld[d] = 1'b1; wr_s[d] = wr; addr_s[d] = a; wdat[d] = wd;
    @(posedge clk); #1;
    vld[d] = 1'b0;
    e = cyc;
    exp_rd = '0;
    if (wr) begin
      case (a)
        3'd0: msip_m[d] = wd[0];
        3'd1: cmp_m[d][31:0] = wd;
        3'd2: cmp_m[d][63:32] = wd;
        3'd3: begin v = mt(d, e - 1); v[31:0]  = wd; base_m[d] = v; anch_m[d] = e; end
        3'd4: begin v = mt(d, e - 1); v[63:32] = wd; base_m[d] = v; anch_m[d] = e; end
        3'd5: begin v = mt(d, e); base_m[d] = v; anch_m[d] = e; en_m[d] = wd[0]; end
        default: ;
      endcase
    end else begin
      case (a)
        3'd0: exp_rd = {31'd0, msip_m[d]};
        3'd1: exp_rd = cmp_m[d][31:0];
        3'd2: exp_rd = cmp_m[d][63:32];
        3'd3: begin v = mt(d, e - 1); exp_rd = v[31:0]; shadow_m[d] = v[63:32]; end
        3'd4: exp_rd = shadow_m[d];
        3'd5: exp_rd = {31'd0, en_m[d]};
        default: exp_rd = '0;
      endcase
    end
    exp_cnt[d]++;
    @(negedge clk);
    check_val("rsp_vld", 64'(rsp_vld[d]), 64'd1);
    check_val("rsp_rdy_low", 64'(rdy[d]), 64'd0);
    check_val(wr ? "rsp_wdata0" : "rsp_rdata", 64'(rdata[d]), 64'(exp_rd));
  endtask

  // Per-cycle monitor: interrupt outputs and response pulse count.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!arst) begin
          have_prev[d] = 1'b0;
        end else begin
          if (have_prev[d]) check_val("mtip_level", 64'(tint[d]), 64'(ge_prev[d]));
          check_val("msip_level", 64'(sint[d]), 64'(msip_m[d]));
          if (rsp_vld[d]) rsp_cnt[d]++;
          ge_prev[d]   = (mt(d, cyc) >= cmp_m[d]);
          have_prev[d] = 1'b1;
        end
      end
    end
  end

  initial begin
    bit found;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; wdat[d] = '0;
      exp_cnt[d] = 0; rsp_cnt[d] = 0; have_prev[d] = 1'b0; ge_prev[d] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    #1 arst = 1'b1;

    // Free-running count from reset on both prescale settings.
    repeat (10) @(negedge clk);
    do_req(0, 1'b0, 3'd3, 32'h0);
    do_req(1, 1'b0, 3'd3, 32'h0);
    do_req(0, 1'b0, 3'd1, 32'h0);
    do_req(0, 1'b0, 3'd5, 32'h0);
    do_req(0, 1'b0, 3'd6, 32'h0);

    // Compare threshold crossing and release.
    do_req(0, 1'b1, 3'd2, 32'h0);
    do_req(0, 1'b1, 3'd3, 32'h0);
    do_req(0, 1'b1, 3'd1, 32'd20);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (tint[0]) begin
        found = 1'b1;
        check_val("mtip_rise_mtime", mt(0, cyc - 1), 64'd20);
      end
    end
    check_val("mtip_rise_seen", 64'(found), 64'd1);
    do_req(0, 1'b1, 3'd1, 32'hFFFF_FFFF);
    check_val("mtip_hold", 64'(tint[0]), 64'd1);
    @(negedge clk);
    check_val("mtip_fall", 64'(tint[0]), 64'd0);
    do_req(0, 1'b1, 3'd2, 32'hFFFF_FFFF);

    // Software interrupt bit.
    do_req(0, 1'b1, 3'd0, 32'hFFFF_FFFF);
    check_val("msip_set", 64'(sint[0]), 64'd1);
    do_req(0, 1'b0, 3'd0, 32'h0);
    do_req(0, 1'b1, 3'd0, 32'h0);
    check_val("msip_clr", 64'(sint[0]), 64'd0);

    // 64-bit wrap and shadowed high-half reads.
    do_req(0, 1'b1, 3'd4, 32'hFFFF_FFFF);
    do_req(0, 1'b1, 3'd3, 32'hFFFF_FFFE);
    do_req(0, 1'b0, 3'd3, 32'h0);
    do_req(0, 1'b0, 3'd4, 32'h0);
    repeat (3) @(negedge clk);
    do_req(0, 1'b0, 3'd3, 32'h0);
    do_req(0, 1'b0, 3'd4, 32'h0);

    // Count enable and prescale-by-4 cadence.
    do_req(1, 1'b1, 3'd5, 32'h0);
    do_req(1, 1'b0, 3'd3, 32'h0);
    repeat (7) @(negedge clk);
    do_req(1, 1'b0, 3'd3, 32'h0);
    do_req(1, 1'b1, 3'd5, 32'h1);
    for (int g = 0; g < 5; g++) begin
      repeat (g) @(negedge clk);
      do_req(1, 1'b0, 3'd3, 32'h0);
    end

    // Held request valid: ready alternates and four responses come back.
    @(negedge clk);
    vld[1] = 1'b1; wr_s[1] = 1'b0; addr_s[1] = 3'd5;
    for (int k = 0; k < 8; k++) begin
      check_val("hold_rdy", 64'(rdy[1]), 64'(k % 2 == 0));
      check_val("hold_rsp", 64'(rsp_vld[1]), 64'(k % 2 == 1));
      if (k % 2 == 1) check_val("hold_rdata", 64'(rdata[1]), 64'(en_m[1]));
      if (k == 7) vld[1] = 1'b0;
      @(negedge clk);
    end
    exp_cnt[1] += 4;

    // Reset asserted in the middle of a response.
    do_req(0, 1'b1, 3'd2, 32'h0);
    do_req(0, 1'b1, 3'd1, 32'h0);
    do_req(0, 1'b1, 3'd0, 32'h1);
    @(negedge clk);
    vld[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 3'd1; wdat[0] = 32'h5;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    #2 arst = 1'b0;
    #1;
    check_reset_outs("abort");
    model_reset();
    repeat (2) @(negedge clk);
    #1 arst = 1'b1;
    repeat (3) @(negedge clk);
    do_req(0, 1'b0, 3'd1, 32'h0);
    do_req(0, 1'b0, 3'd2, 32'h0);
    do_req(1, 1'b0, 3'd2, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      int          d;
      logic        wr;
      logic [2:0]  a;
      logic [31:0] wd;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd5) wd = ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(d, wr, a, wd);
    end
    repeat (3) @(negedge clk);

    check_val("rsp_count_p1", 64'(rsp_cnt[0]), 64'(exp_cnt[0]));
    check_val("rsp_count_p4", 64'(rsp_cnt[1]), 64'(exp_cnt[1]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
